// File: rtl/fuzz_seq_pkg.sv
// Shared constants, state type and helpers for the fuzz run sequencer.
// Pure declarations: no latency; no backpressure.
package fuzz_seq_pkg;

  localparam int FOLD_W = 256;

  localparam logic [63:0] LFSR_POLY = 64'hD800000000000000;
  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_WARMUP,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Bit-field placement of the four DUT inputs inside the 64-bit LFSR
  localparam int STIM0_LSB = 0;
  localparam int STIM0_W   = 19;
  localparam int STIM1_LSB = 19;
  localparam int STIM1_W   = 21;
  localparam int STIM2_LSB = 40;
  localparam int STIM2_W   = 9;
  localparam int STIM3_LSB = 49;
  localparam int STIM3_W   = 15;

  function automatic logic [31:0] fold256(input logic [FOLD_W-1:0] v);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < FOLD_W / 32; i++) begin
      acc = acc ^ v[i*32 +: 32];
    end
    return acc;
  endfunction

  function automatic logic [63:0] lfsr_step(input logic [63:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 64'h0);
  endfunction

endpackage

// File: rtl/fuzz_misr.sv
// 32-bit MISR over the folded DUT output bus; one update per enabled cycle, result next edge.
// No backpressure: every enabled cycle is absorbed; clear has priority over enable.
module fuzz_misr
  import fuzz_seq_pkg::*;
#(
  parameter int Y_W = 242
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           en,
  input  logic [Y_W-1:0] data,
  output logic [31:0]    sig
);

  logic [FOLD_W-1:0] w_ext;
  logic [31:0]       r_sig;

  assign w_ext = FOLD_W'(data);
  assign sig   = r_sig;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (clear) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= {r_sig[30:0], 1'b0} ^ (r_sig[31] ? MISR_POLY : 32'h0) ^ fold256(w_ext);
    end
  end

endmodule

// File: rtl/fuzz_run_sequencer.sv
// Seeds an LFSR, drives the DUT inputs, warms up, runs N vectors and signs y into a MISR.
// Done arrives 1+WARMUP+N+DRAIN_LAT edges after the start edge (1 when N=0); start ignored while busy.
module fuzz_run_sequencer
  import fuzz_seq_pkg::*;
#(
  parameter int Y_W       = 242,
  parameter int SIG_W     = 32,
  parameter int WARMUP    = 4,
  parameter int DRAIN_LAT = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      seed,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic [SIG_W-1:0] golden_sig,
  input  logic [Y_W-1:0]   dut_y,
  output logic [18:0]      stim_wire0,
  output logic [20:0]      stim_wire1,
  output logic [8:0]       stim_wire2,
  output logic [14:0]      stim_wire3,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] vec_count
);

  state_t               r_state;
  state_t               w_next;
  logic [63:0]          r_lfsr;
  logic [CNT_W-1:0]     r_vec_cnt;
  logic [CNT_W-1:0]     r_cyc_cnt;
  logic [CNT_W-1:0]     r_nv;
  logic [SIG_W-1:0]     r_golden;
  logic [DRAIN_LAT-1:0] r_pipe;
  logic                 w_accept;
  logic                 w_pipe_in;
  logic                 w_cap;
  logic                 w_clear;
  logic [SIG_W-1:0]     w_sig;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_pipe_in = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next   = ST_SEED;
          w_accept = 1'b1;
        end
      end
      ST_SEED: begin
        busy   = 1'b1;
        w_next = (r_nv == '0) ? ST_DONE : ST_WARMUP;
      end
      ST_WARMUP: begin
        busy = 1'b1;
        if (r_cyc_cnt == CNT_W'(WARMUP - 1)) w_next = ST_RUN;
      end
      ST_RUN: begin
        busy      = 1'b1;
        w_pipe_in = 1'b1;
        if (r_vec_cnt == r_nv - CNT_W'(1)) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (r_cyc_cnt == CNT_W'(DRAIN_LAT - 1)) w_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        pass = (w_sig == r_golden);
        if (start) begin
          w_next   = ST_SEED;
          w_accept = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr    <= 64'h1;
      r_vec_cnt <= '0;
      r_cyc_cnt <= '0;
      r_nv      <= '0;
      r_golden  <= '0;
      r_pipe    <= '0;
    end else begin
      if (w_accept) begin
        r_nv     <= num_vectors;
        r_golden <= golden_sig;
      end

      // Capture flags mature DRAIN_LAT edges after their RUN cycle, lining up with y
      r_pipe[0] <= w_pipe_in;
      for (int i = 1; i < DRAIN_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end

      case (r_state)
        ST_SEED: begin
          r_lfsr    <= (seed == 64'h0) ? 64'h1 : seed;
          r_vec_cnt <= '0;
          r_cyc_cnt <= '0;
        end
        ST_WARMUP: begin
          r_lfsr    <= lfsr_step(r_lfsr);
          r_cyc_cnt <= (w_next != r_state) ? '0 : r_cyc_cnt + CNT_W'(1);
        end
        ST_RUN: begin
          r_lfsr    <= lfsr_step(r_lfsr);
          r_vec_cnt <= r_vec_cnt + CNT_W'(1);
          r_cyc_cnt <= '0;
        end
        ST_DRAIN: begin
          r_cyc_cnt <= (w_next != r_state) ? '0 : r_cyc_cnt + CNT_W'(1);
        end
        default: begin
          r_cyc_cnt <= '0;
        end
      endcase
    end
  end

  assign w_cap   = r_pipe[DRAIN_LAT-1];
  assign w_clear = (r_state == ST_SEED);

  fuzz_misr #(
    .Y_W (Y_W)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .en    (w_cap),
    .data  (dut_y),
    .sig   (w_sig)
  );

  assign stim_wire0 = r_lfsr[STIM0_LSB +: STIM0_W];
  assign stim_wire1 = r_lfsr[STIM1_LSB +: STIM1_W];
  assign stim_wire2 = r_lfsr[STIM2_LSB +: STIM2_W];
  assign stim_wire3 = r_lfsr[STIM3_LSB +: STIM3_W];
  assign signature  = w_sig;
  assign vec_count  = r_vec_cnt;

endmodule

// File: tb/tb_fuzz_run_sequencer.sv
// Bench for fuzz_run_sequencer: a stand-in two-register DUT feeds y, a scoreboard checks each run.
module tb_fuzz_run_sequencer;

  localparam int Y_W       = 242;
  localparam int CNT_W     = 16;
  localparam int WARMUP    = 4;
  localparam int DRAIN_LAT = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [63:0]      seed_in;
  logic [CNT_W-1:0] num_vectors;
  logic [31:0]      golden_sig;
  logic [Y_W-1:0]   dut_y;
  logic [18:0]      stim_wire0;
  logic [20:0]      stim_wire1;
  logic [8:0]       stim_wire2;
  logic [14:0]      stim_wire3;
  logic             busy, done, pass;
  logic [31:0]      signature;
  logic [CNT_W-1:0] vec_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fuzz_run_sequencer #(
    .Y_W(Y_W), .SIG_W(32), .WARMUP(WARMUP), .DRAIN_LAT(DRAIN_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed_in),
    .num_vectors(num_vectors), .golden_sig(golden_sig), .dut_y(dut_y),
    .stim_wire0(stim_wire0), .stim_wire1(stim_wire1), .stim_wire2(stim_wire2),
    .stim_wire3(stim_wire3), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .vec_count(vec_count)
  );

  // Stand-in DUT: two register stages, so y matches the stimulus two cycles later
  function automatic logic [Y_W-1:0] dut_f(input logic [63:0] v);
    return {v[49:0], v ^ {v[31:0], v[63:32]}, ~v, v};
  endfunction

  logic [63:0]    w_stim, d1, d2;
  logic           y_mode = 1'b0;
  logic [Y_W-1:0] y_const = '0;
  assign w_stim = {stim_wire3, stim_wire2, stim_wire1, stim_wire0};
  always @(posedge clk) begin
    d1 <= w_stim;
    d2 <= d1;
  end
  assign dut_y = y_mode ? y_const : dut_f(d2);

  // Reference model: the run as a plain sequence of LFSR states and MISR steps
  function automatic logic [63:0] m_lfsr(input logic [63:0] v);
    return v[0] ? ((v >> 1) ^ 64'hD800000000000000) : (v >> 1);
  endfunction

  function automatic logic [31:0] m_fold(input logic [Y_W-1:0] y);
    logic [255:0] t;
    logic [31:0]  a;
    t = {{(256-Y_W){1'b0}}, y};
    a = 32'h0;
    for (int i = 0; i < 8; i++) a = a ^ t[i*32 +: 32];
    return a;
  endfunction

  function automatic logic [31:0] model_sig(input logic [63:0] sd, input int nv,
                                            input logic mode, input logic [Y_W-1:0] yc);
    logic [63:0] s;
    logic [31:0] sg;
    s = (sd == 64'h0) ? 64'h1 : sd;
    for (int i = 0; i < WARMUP; i++) s = m_lfsr(s);
    sg = 32'h0;
    for (int i = 0; i < nv; i++) begin
      sg = {sg[30:0], 1'b0} ^ (sg[31] ? 32'h04C11DB7 : 32'h0) ^ m_fold(mode ? yc : dut_f(s));
      s  = m_lfsr(s);
    end
    return sg;
  endfunction

  typedef struct {
    logic [31:0]      sig;
    logic             pass;
    logic [CNT_W-1:0] nv;
    int               done_cyc;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising done is matched against the oldest queued expectation
  logic prev_done = 1'b0;
  exp_t e_mon;
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done rose with empty scoreboard (cycle %0d)", cyc);
      end else begin
        e_mon = q.pop_front();
        check("signature", 64'(signature), 64'(e_mon.sig));
        check("pass", 64'(pass), 64'(e_mon.pass));
        check("vec_count", 64'(vec_count), 64'(e_mon.nv));
        check("done_cycle", 64'(cyc), 64'(e_mon.done_cyc));
        check("busy_in_done", 64'(busy), 64'h0);
      end
    end
    prev_done <= done;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'h0);
    check({tag, "_done"}, 64'(done), 64'h0);
    check({tag, "_pass"}, 64'(pass), 64'h0);
    check({tag, "_sig"}, 64'(signature), 64'h0);
    check({tag, "_vec"}, 64'(vec_count), 64'h0);
    check({tag, "_stim0"}, 64'(stim_wire0), 64'h1);
    check({tag, "_stim123"}, 64'({stim_wire3, stim_wire2, stim_wire1}), 64'h0);
  endtask

  task automatic pulse_garbage_start();
    seed_in     = {$urandom, $urandom};
    num_vectors = CNT_W'($urandom);
    golden_sig  = $urandom;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_run(input logic [63:0] sd, input int nv, input logic [31:0] gold,
                        input logic mode, input logic [Y_W-1:0] yc, input bit inject);
    exp_t        e;
    logic [63:0] s0;
    int          n;
    int          s_cyc;
    s0 = (sd == 64'h0) ? 64'h1 : sd;
    @(negedge clk);
    seed_in     = sd;
    num_vectors = CNT_W'(nv);
    golden_sig  = gold;
    y_mode      = mode;
    y_const     = yc;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_cyc = cyc;
    // Start edge, SEED, then WARMUP + N + DRAIN_LAT when N is non-zero
    e.sig      = model_sig(sd, nv, mode, yc);
    e.pass     = (e.sig == gold);
    e.nv       = CNT_W'(nv);
    e.done_cyc = s_cyc + 1 + ((nv == 0) ? 0 : (WARMUP + nv + DRAIN_LAT));
    q.push_back(e);
    check("start_busy", 64'(busy), 64'h1);
    check("start_clears_done", 64'(done), 64'h0);
    check("start_clears_pass", 64'(pass), 64'h0);
    @(negedge clk);
    check("seeded_stim", 64'(w_stim), s0);
    if (inject && nv > 0) begin
      pulse_garbage_start();
      repeat (WARMUP - 2) @(negedge clk);
      pulse_garbage_start();
    end
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL run_timeout: done not seen after %0d cycles (expected by cycle %0d)", n, e.done_cyc);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0]   t;
    logic [Y_W-1:0] yc;
    logic [63:0]    sd;
    int             nv;
    int             n;
    logic           mode;
    logic [31:0]    g;

    rst_n = 1'b0; start = 1'b0; seed_in = '0; num_vectors = '0; golden_sig = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");

    do_run(64'h0123456789ABCDEF, 1, 32'h1, 1'b1, Y_W'(1), 1'b0);
    do_run(64'h0, 0, 32'h0, 1'b1, '0, 1'b0);
    do_run(64'hFEDCBA9876543210, 3, 32'h5, 1'b1, '0, 1'b0);
    do_run(64'h0000000000000001, 1, 32'h0, 1'b0, '0, 1'b0);
    sd = 64'hA5A5_0F0F_3C3C_9999;
    do_run(sd, 9, model_sig(sd, 9, 1'b0, '0), 1'b0, '0, 1'b1);

    // Reset in the middle of RUN
    @(negedge clk);
    seed_in = 64'h1234_5678_9ABC_DEF0; num_vectors = 20; golden_sig = 32'h0; y_mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (vec_count != 7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_vec7", 64'(vec_count), 64'd7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("midrun_reset");
    @(negedge clk);
    check("idle_after_reset_busy", 64'(busy), 64'h0);
    sd = 64'h1234_5678_9ABC_DEF0;
    do_run(sd, 20, model_sig(sd, 20, 1'b0, '0), 1'b0, '0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      sd   = {$urandom, $urandom};
      nv   = $urandom_range(1, 40);
      mode = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
      yc = t[Y_W-1:0];
      g  = model_sig(sd, nv, mode, yc);
      if ($urandom_range(0, 2) == 0) g = g ^ 32'h0000_0100;
      do_run(sd, nv, g, mode, yc, ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
